simon_engine: RTL and testbench
===============================

# simon_engine

Parametrised SIMON block-cipher engine, successor to the fixed-size SIMON control block. It serves every SIMON family member (word size, key words, round count, z-sequence) and both encrypt and decrypt. It keeps the expanded round-key store so back-to-back blocks can reuse a key, and it can retire multiple rounds per cycle. It sits between the packet front-end (valid/ready input with an 8-bit tag) and the output packer (valid/ready output).

## Interface
Parameters:
- N, 16, word size in bits; block is 2N.
- M, 4, key words; legal values are 2, 3, 4.
- T, 32, rounds.
- ZI, 0, z-sequence index (0..4).
- UNROLL, 1, rounds per cycle; T % UNROLL == 0 is required.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on rising edge.
- R  in  1  synchronous active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  engine accepts a request this cycle.
- in_data  in  2N  [2N-1:N]=x, [N-1:0]=y.
- in_key  in  M*N  word i at [i*N+:N], k0 in the LSBs.
- in_key_new  in  1  load and expand in_key with this request.
- in_dec  in  1  1=decrypt, 0=encrypt.
- in_tag  in  8  opaque tag, returned with the result.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes the result.
- out_data  out  2N  result, same packing as in_data.
- out_tag  out  8  tag of this result.
- out_dec  out  1  mode of this result.
- key_valid  out  1  round-key store holds an expanded key.

## Operation
- States: IDLE, KEYEXP, RUN, HOLD. in_ready = (state==IDLE) && !R.
- Accept: in_valid && in_ready at an edge.
  - Latch data, tag and mode.
  - If in_key_new || !key_valid: write k0..k(M-1) into store[0..M-1], clear key_valid, go to KEYEXP.
  - Otherwise go to RUN.
- KEYEXP: one word per cycle, i = M..T-1.
  - tmp = rotr3(k[i-1]); if M==4, tmp ^= k[i-3]; tmp ^= rotr1(tmp).
  - k[i] = ~k[i-M] ^ tmp ^ z[ZI][(i-M)%62] ^ 3.
  - After k[T-1] is written, set key_valid and go to RUN.
- Round function: x' = y ^ (rotl1(x) & rotl8(x)) ^ rotl2(x) ^ key; y' = x.
  - Encrypt uses keys 0..T-1.
  - Decrypt swaps x/y on entry, uses keys T-1..0, and swaps x/y on exit.
- RUN: UNROLL chained rounds per cycle. The round counter is $clog2(T+1) bits wide and advances by UNROLL.
  - On the last group the result is registered into out_data, with out_tag/out_dec, and the state goes to HOLD.
- HOLD: out_valid=1; out_data/out_tag/out_dec are stable. On out_ready, go to IDLE.
- in_valid while not IDLE is ignored; in_key is don't-care when key reuse applies.
- All rotations are modulo N; all arithmetic is N-bit wrap.

## Timing
- Reset values: in_ready=0 during R, 1 on the first cycle after R; out_valid=0, out_data=0, out_tag=0, out_dec=0, key_valid=0; state=IDLE; store contents are don't-care.
- Latency with key reuse: out_valid rises T/UNROLL edges after the accept edge.
- Latency with key load: out_valid rises (T-M) + T/UNROLL edges after the accept edge.
- out_ready already high when out_valid rises: handshake completes at the next edge and in_ready=1 the cycle after. Minimum issue interval is T/UNROLL+2 cycles.
- R asserted in any state: all outputs return to reset values at that edge. A partially expanded key is discarded (key_valid=0) and an in-flight block is dropped with no output.
- in_valid held high across HOLD: the next request is accepted only in IDLE, never in the same cycle as the out handshake.

## Configuration
- SIMON_DECRYPT_EN defined: decrypt path (swaps, reverse key indexing) is present and in_dec selects the mode.
- SIMON_DECRYPT_EN undefined: in_dec is ignored, every request encrypts, and out_dec is always 0.

## Test plan
- SIMON32/64 encrypt (defaults): key 1918_1110_0908_0100, pt 6565_6877, in_key_new=1 -> out_data c69b_e9bb, out_valid 60 edges after accept, key_valid=1.
- Decrypt with key reuse (SIMON_DECRYPT_EN): c69b_e9bb, in_dec=1, in_key_new=0 -> 6565_6877 after 32 edges, out_dec=1, tag echoed.
- SIMON64/128 (N=32, M=4, T=44, ZI=3, UNROLL=2): key 1b1a1918_13121110_0b0a0908_03020100, pt 656b696c_20646e75 -> 44c8fc20_b9dfa07a after 40+22 edges.
- Back-pressure: out_ready held 0 for 10 cycles -> out_valid, out_data and out_tag stable, in_ready=0, extra in_valid ignored; out_ready=1 -> IDLE next edge.
- R pulsed mid-KEYEXP and mid-RUN -> key_valid=0, out_valid=0. The next request with in_key_new=0 still performs a full key load.
- Build without SIMON_DECRYPT_EN: in_dec=1 on the SIMON32/64 vector -> c69b_e9bb, out_dec=0.

Source files
------------

// File: rtl/simon_engine.sv
// -----------------------------------------------------------------------------
// simon_engine
//   Parametrised SIMON block-cipher engine (any word size / key words / round
//   count / z-sequence). Keeps the expanded round-key store between requests
//   so a key can be reused, and retires UNROLL rounds per clock.
//
//   States:
//     state  | meaning
//     -------+--------------------------------------------------------------
//     IDLE   | waiting for a request, in_ready high
//     KEYEXP | expanding one round key per cycle, words M..T-1
//     RUN    | applying UNROLL rounds per cycle
//     HOLD   | result presented on out_*, waiting for out_ready
//
//   Parameters: N word bits, M key words (2..4), T rounds, ZI z-sequence index,
//               UNROLL rounds per cycle (T % UNROLL == 0).
//
//   Ports:
//     clk, R                    clock, synchronous active-high reset
//     in_valid/in_ready         request handshake
//     in_data [2N]              {x, y}
//     in_key  [M*N]             key words, k0 in the LSBs
//     in_key_new, in_dec        reload key / decrypt request
//     in_tag  [8]               opaque tag returned with the result
//     out_valid/out_ready       result handshake
//     out_data, out_tag, out_dec result, its tag and mode
//     key_valid                 round-key store holds a fully expanded key
//
//   Build option: SIMON_DECRYPT_EN enables the decrypt path; without it in_dec
//   is ignored and every request encrypts.
// -----------------------------------------------------------------------------
module simon_engine #(
    parameter int N      = 16,
    parameter int M      = 4,
    parameter int T      = 32,
    parameter int ZI     = 0,
    parameter int UNROLL = 1
) (
    input  logic             clk,
    input  logic             R,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   in_data,
    input  logic [M*N-1:0]   in_key,
    input  logic             in_key_new,
    input  logic             in_dec,
    input  logic [7:0]       in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_data,
    output logic [7:0]       out_tag,
    output logic             out_dec,
    output logic             key_valid
);

    localparam int CW = $clog2(T + 1);
    localparam int KW = (T > 1) ? $clog2(T) : 1;

    // z-sequences stored bit-reversed so that bit j is z[j].
    localparam logic [61:0] Z0 = 62'b01100111000011010100100010111110110011100001101010010001011111;
    localparam logic [61:0] Z1 = 62'b01011010000110010011111011100010101101000011001001111101110001;
    localparam logic [61:0] Z2 = 62'b11001101101001111110001000010100011001001011000000111011110101;
    localparam logic [61:0] Z3 = 62'b11110000101100111001010001001000000111101001100011010111011011;
    localparam logic [61:0] Z4 = 62'b11110111001001010011000011101000000100011011010110011110001011;
    localparam logic [61:0] Z_SEL = (ZI == 0) ? Z0 :
                                    (ZI == 1) ? Z1 :
                                    (ZI == 2) ? Z2 :
                                    (ZI == 3) ? Z3 : Z4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYEXP = 2'd1,
        RUN    = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [N-1:0]  store [T];
    logic [CW-1:0] kidx;
    logic [CW-1:0] rnd;
    logic [5:0]    zidx;
    logic [N-1:0]  x_q, y_q;
    logic [7:0]    tag_q;
    logic          dec_q;
    logic          dec_in;
    logic          accept;
    logic          load_key;
    logic          kexp_last;
    logic          run_last;
    logic [N-1:0]  k_new;
    logic [N-1:0]  rx_fin, ry_fin;

    function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input int s);
        return (v << s) | (v >> (N - s));
    endfunction

    function automatic logic [N-1:0] rotr(input logic [N-1:0] v, input int s);
        return (v >> s) | (v << (N - s));
    endfunction

`ifdef SIMON_DECRYPT_EN
    assign dec_in = in_dec;
`else
    logic unused_dec;
    assign unused_dec = in_dec;
    assign dec_in     = 1'b0;
`endif

    assign in_ready  = (state == IDLE) && !R;
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;
    assign load_key  = in_key_new || !key_valid;
    assign kexp_last = (kidx == CW'(T - 1));
    assign run_last  = (rnd == CW'(T - UNROLL));

    // Next key word from the words already in the store.
    always_comb begin
        logic [N-1:0] tmp;
        tmp = rotr(store[KW'(kidx - CW'(1))], 3);
        if (M == 4) begin
            tmp = tmp ^ store[KW'(kidx - CW'(3))];
        end
        tmp   = tmp ^ rotr(tmp, 1);
        k_new = ~store[KW'(kidx - CW'(M))] ^ tmp ^ N'(Z_SEL[zidx]) ^ N'(3);
    end

    // UNROLL chained rounds; decrypt walks the key store backwards.
    always_comb begin
        logic [N-1:0] cx, cy, rk;
        int           ki;
        cx = x_q;
        cy = y_q;
        rk = '0;
        ki = 0;
        for (int u = 0; u < UNROLL; u++) begin
            ki = int'(rnd) + u;
            if (dec_q) begin
                ki = T - 1 - ki;
            end
            rk = store[KW'(ki)];
            {cx, cy} = {cy ^ (rotl(cx, 1) & rotl(cx, 8)) ^ rotl(cx, 2) ^ rk, cx};
        end
        rx_fin = cx;
        ry_fin = cy;
    end

    always_ff @(posedge clk) begin
        if (R) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nx = load_key ? KEYEXP : RUN;
                end
            end
            KEYEXP: begin
                if (kexp_last) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (run_last) begin
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (R) begin
            key_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            out_dec   <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            tag_q     <= '0;
            dec_q     <= 1'b0;
            kidx      <= '0;
            rnd       <= '0;
            zidx      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        tag_q <= in_tag;
                        dec_q <= dec_in;
                        rnd   <= '0;
                        kidx  <= CW'(M);
                        zidx  <= '0;
                        // Decrypt enters with the halves swapped.
                        if (dec_in) begin
                            x_q <= in_data[N-1:0];
                            y_q <= in_data[2*N-1:N];
                        end else begin
                            x_q <= in_data[2*N-1:N];
                            y_q <= in_data[N-1:0];
                        end
                        if (load_key) begin
                            key_valid <= 1'b0;
                        end
                    end
                end
                KEYEXP: begin
                    kidx <= kidx + CW'(1);
                    zidx <= (zidx == 6'd61) ? 6'd0 : zidx + 6'd1;
                    if (kexp_last) begin
                        key_valid <= 1'b1;
                    end
                end
                RUN: begin
                    x_q <= rx_fin;
                    y_q <= ry_fin;
                    rnd <= rnd + CW'(UNROLL);
                    if (run_last) begin
                        out_data <= dec_q ? {ry_fin, rx_fin} : {rx_fin, ry_fin};
                        out_tag  <= tag_q;
                        out_dec  <= dec_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Key store carries no reset; key_valid alone says whether it is usable.
    always_ff @(posedge clk) begin
        if (accept && load_key) begin
            for (int i = 0; i < M; i++) begin
                store[KW'(i)] <= in_key[i*N +: N];
            end
        end else if (state == KEYEXP) begin
            store[KW'(kidx)] <= k_new;
        end
    end

endmodule

// File: tb/tb_simon_engine.sv
module tb_simon_engine;

    logic         clk;
    logic         R;

    // SIMON32/64 instance (defaults)
    logic         in_valid, in_ready, in_key_new, in_dec, out_valid, out_ready, out_dec, key_valid;
    logic [31:0]  in_data, out_data;
    logic [63:0]  in_key;
    logic [7:0]   in_tag, out_tag;

    // SIMON64/128 instance, two rounds per cycle
    logic         b_in_valid, b_in_ready, b_in_key_new, b_in_dec, b_out_valid, b_out_ready, b_out_dec, b_key_valid;
    logic [63:0]  b_in_data, b_out_data;
    logic [127:0] b_in_key;
    logic [7:0]   b_in_tag, b_out_tag;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [63:0] KEY32 = 64'h1918_1110_0908_0100;
    localparam logic [31:0] PT32  = 32'h6565_6877;
    localparam logic [31:0] CT32  = 32'hc69b_e9bb;

`ifdef SIMON_DECRYPT_EN
    localparam logic [31:0] DEC_IN  = CT32;
    localparam logic [31:0] DEC_EXP = PT32;
    localparam logic        DEC_OUT = 1'b1;
`else
    localparam logic [31:0] DEC_IN  = PT32;
    localparam logic [31:0] DEC_EXP = CT32;
    localparam logic        DEC_OUT = 1'b0;
`endif

    simon_engine dut (
        .clk(clk), .R(R),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
        .in_key_new(in_key_new), .in_dec(in_dec), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_dec(out_dec), .key_valid(key_valid)
    );

    simon_engine #(.N(32), .M(4), .T(44), .ZI(3), .UNROLL(2)) dut64 (
        .clk(clk), .R(R),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_key(b_in_key),
        .in_key_new(b_in_key_new), .in_dec(b_in_dec), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_tag(b_out_tag), .out_dec(b_out_dec), .key_valid(b_key_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request on the 32/64 engine and wait for its result (left in HOLD).
    task automatic run_a(input string nm, input logic [31:0] d, input logic kn, input logic dn,
                         input logic [7:0] tg, input int exp_lat, input logic [31:0] exp_d,
                         input logic exp_dec);
        int lat;
        @(negedge clk);
        in_valid   = 1'b1;
        in_data    = d;
        in_key     = KEY32;
        in_key_new = kn;
        in_dec     = dn;
        in_tag     = tg;
        chk({nm, " in_ready"}, 128'(in_ready), 128'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 400) begin
            @(posedge clk);
            #1 lat++;
        end
        chk({nm, " latency"}, 128'(lat), 128'(exp_lat));
        chk({nm, " data"}, 128'(out_data), 128'(exp_d));
        chk({nm, " tag"}, 128'(out_tag), 128'(tg));
        chk({nm, " dec"}, 128'(out_dec), 128'(exp_dec));
        chk({nm, " key_valid"}, 128'(key_valid), 128'(1));
    endtask

    task automatic release_a(input string nm);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({nm, " released out_valid"}, 128'(out_valid), 128'(0));
        chk({nm, " released in_ready"}, 128'(in_ready), 128'(1));
        out_ready = 1'b0;
    endtask

    task automatic pulse_reset(input string nm);
        @(negedge clk);
        R = 1'b1;
        @(posedge clk);
        #1;
        chk({nm, " key_valid"}, 128'(key_valid), 128'(0));
        chk({nm, " out_valid"}, 128'(out_valid), 128'(0));
        chk({nm, " out_data"}, 128'(out_data), 128'(0));
        chk({nm, " in_ready during R"}, 128'(in_ready), 128'(0));
        @(negedge clk);
        R = 1'b0;
        #1 chk({nm, " in_ready after R"}, 128'(in_ready), 128'(1));
    endtask

    initial begin
        int lat;
        logic [31:0] held_d;
        R = 1'b1;
        in_valid = 0; in_data = '0; in_key = '0; in_key_new = 0; in_dec = 0; in_tag = '0; out_ready = 0;
        b_in_valid = 0; b_in_data = '0; b_in_key = '0; b_in_key_new = 0; b_in_dec = 0; b_in_tag = '0;
        b_out_ready = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", 128'(in_ready), 128'(0));
        chk("reset out_valid", 128'(out_valid), 128'(0));
        chk("reset out_data", 128'(out_data), 128'(0));
        chk("reset out_tag", 128'(out_tag), 128'(0));
        chk("reset out_dec", 128'(out_dec), 128'(0));
        chk("reset key_valid", 128'(key_valid), 128'(0));
        @(negedge clk);
        R = 1'b0;
        #1 chk("first cycle in_ready", 128'(in_ready), 128'(1));

        // Encrypt with key load
        run_a("enc32 load", PT32, 1'b1, 1'b0, 8'h5a, 60, CT32, 1'b0);

        // Back-pressure: hold for 10 cycles with a competing request on in_valid
        held_d = out_data;
        @(negedge clk);
        in_valid = 1'b1; in_data = PT32; in_key_new = 1'b0; in_dec = 1'b0; in_tag = 8'h33;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp out_valid", 128'(out_valid), 128'(1));
            chk("bp out_data", 128'(out_data), 128'(held_d));
            chk("bp out_tag", 128'(out_tag), 128'(8'h5a));
            chk("bp in_ready", 128'(in_ready), 128'(0));
        end
        // Release with in_valid still high: IDLE first, acceptance on the edge after.
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp release out_valid", 128'(out_valid), 128'(0));
        chk("bp release in_ready", 128'(in_ready), 128'(1));
        out_ready = 1'b0;
        // Same request continues; key reuse encrypt
        run_a("enc32 reuse", PT32, 1'b0, 1'b0, 8'h33, 32, CT32, 1'b0);
        release_a("enc32 reuse");

        // Decrypt request with key reuse (encrypts when decrypt is not built)
        run_a("dec32 reuse", DEC_IN, 1'b0, 1'b1, 8'hc4, 32, DEC_EXP, DEC_OUT);
        release_a("dec32 reuse");

        // Reset in the middle of key expansion
        @(negedge clk);
        in_valid = 1'b1; in_data = PT32; in_key = KEY32; in_key_new = 1'b1; in_dec = 1'b0; in_tag = 8'h01;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        pulse_reset("rst keyexp");
        run_a("after rst keyexp", PT32, 1'b0, 1'b0, 8'h02, 60, CT32, 1'b0);
        release_a("after rst keyexp");

        // Reset in the middle of rounds
        @(negedge clk);
        in_valid = 1'b1; in_data = PT32; in_key_new = 1'b0; in_dec = 1'b0; in_tag = 8'h03;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        pulse_reset("rst run");
        run_a("after rst run", PT32, 1'b0, 1'b0, 8'h04, 60, CT32, 1'b0);
        release_a("after rst run");

        // SIMON64/128, UNROLL=2
        @(negedge clk);
        b_in_valid = 1'b1;
        b_in_data = 64'h656b696c_20646e75;
        b_in_key = 128'h1b1a1918_13121110_0b0a0908_03020100;
        b_in_key_new = 1'b1; b_in_dec = 1'b0; b_in_tag = 8'h77;
        chk("s64 in_ready", 128'(b_in_ready), 128'(1));
        @(posedge clk);
        #1 b_in_valid = 1'b0;
        lat = 0;
        while (!b_out_valid && lat < 400) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("s64 latency", 128'(lat), 128'(62));
        chk("s64 data", 128'(b_out_data), 128'(64'h44c8fc20_b9dfa07a));
        chk("s64 tag", 128'(b_out_tag), 128'(8'h77));
        chk("s64 key_valid", 128'(b_key_valid), 128'(1));
        @(negedge clk);
        b_out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("s64 released in_ready", 128'(b_in_ready), 128'(1));
        b_out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
